// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider helper. The transmitter picks these up as well.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   // Ticks per oversample slot; never below one so a fast baud still ticks.
   function automatic int baud_div(input int clk_freq, input int baud);
      int d;
      d = clk_freq / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream: one-entry holding register with valid/ready,
// plus line status. The receiver is the master; the consumer is the slave.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   modport master (
      output data, valid, busy, frame_err, overrun,
      input  ready
   );

   modport slave (
      input  data, valid, busy, frame_err, overrun,
      output ready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);
   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..DIV-1 and wrap; only reset ever realigns the phase.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, majority-voted bits, one-entry
// valid/ready holding register with frame-error and overrun pulses.
//
//  state | meaning
//  IDLE  | line idle, waiting for a low sample (only after line seen high)
//  START | start bit: glitch check at mid sample, then run out the bit
//  DATA  | eight data bits, LSB first, vote on samples 7/8/9
//  STOP  | stop bit, vote on samples 6/7/8, deliver or flag at sample 8
//  BREAK | stop bit was low; wait for the line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_rx,
   uart_rx_if.master io_bus
);
   localparam int         DIV       = baud_div(CLK_FREQ, BAUD);
   localparam logic [3:0] SAMP_MID  = 4'(MID_SAMPLE);
   localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

   logic       w_tick;
   logic       r_rx_meta;
   logic       r_rx_s;
   logic [1:0] r_flush;
   logic       r_armed;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_samp, w_samp_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic [1:0] r_vote, w_vote_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_ferr, w_ferr_nxt;
   logic       r_ovr, w_ovr_nxt;
   logic       w_accept;
   logic       w_maj;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (w_tick)
   );

   // Two-flop synchronizer. The armed flag only sets once the synchronizer
   // has flushed its reset ones and shows a real high, so a reset landing
   // while the line is low cannot be mistaken for a start edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_flush   <= 2'b00;
         r_armed   <= 1'b0;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_flush   <= {r_flush[0], 1'b1};
         if (r_flush[1] && r_rx_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_samp  <= '0;
         r_bit   <= '0;
         r_vote  <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_samp  <= w_samp_nxt;
         r_bit   <= w_bit_nxt;
         r_vote  <= w_vote_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   // Next-state logic; the frame only advances on oversample ticks while the
   // handshake is evaluated every clock. START runs its full sixteen slots so
   // DATA slot numbers line up with bit boundaries and slot 8 is mid-bit.
   always_comb begin
      w_state_nxt = r_state;
      w_samp_nxt  = r_samp;
      w_bit_nxt   = r_bit;
      w_vote_nxt  = r_vote;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;

      w_accept = r_valid & io_bus.ready;
      w_maj    = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_s) | (r_vote[1] & r_rx_s);

      if (w_accept) begin
         w_valid_nxt = 1'b0;
      end

      if (w_tick) begin
         case (r_state)
            IDLE: begin
               if (r_armed && !r_rx_s) begin
                  w_state_nxt = START;
                  w_samp_nxt  = '0;
               end
            end
            START: begin
               w_samp_nxt = r_samp + 4'd1;
               if (r_samp == SAMP_MID && r_rx_s) begin
                  w_state_nxt = IDLE;
               end else if (r_samp == SAMP_LAST) begin
                  w_state_nxt = DATA;
                  w_samp_nxt  = '0;
                  w_bit_nxt   = '0;
               end
            end
            DATA: begin
               w_samp_nxt = r_samp + 4'd1;
               if (r_samp == SAMP_MID) begin
                  w_vote_nxt[0] = r_rx_s;
               end
               if (r_samp == SAMP_MID + 4'd1) begin
                  w_vote_nxt[1] = r_rx_s;
               end
               if (r_samp == SAMP_MID + 4'd2) begin
                  w_shift_nxt = {w_maj, r_shift[7:1]};
               end
               if (r_samp == SAMP_LAST) begin
                  w_samp_nxt = '0;
                  if (r_bit == 3'd7) begin
                     w_state_nxt = STOP;
                  end else begin
                     w_bit_nxt = r_bit + 3'd1;
                  end
               end
            end
            STOP: begin
               w_samp_nxt = r_samp + 4'd1;
               if (r_samp == SAMP_MID - 4'd1) begin
                  w_vote_nxt[0] = r_rx_s;
               end
               if (r_samp == SAMP_MID) begin
                  w_vote_nxt[1] = r_rx_s;
               end
               if (r_samp == SAMP_MID + 4'd1) begin
                  if (w_maj) begin
                     // an accept on this same cycle frees the slot for the new byte
                     if (r_valid && !w_accept) begin
                        w_ovr_nxt = 1'b1;
                     end else begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                     end
                     w_state_nxt = IDLE;
                  end else begin
                     w_ferr_nxt  = 1'b1;
                     w_state_nxt = BREAK;
                  end
               end
            end
            BREAK: begin
               if (r_rx_s) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign io_bus.data      = r_data;
   assign io_bus.valid     = r_valid;
   assign io_bus.busy      = (r_state != IDLE);
   assign io_bus.frame_err = r_ferr;
   assign io_bus.overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed frames plus a randomized
// run, all checked every cycle against a frame-level model of the receiver.
module tb_uart_rx;
   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   // start edge to valid: 9.5 bit times (152 clk) + 2 sync + detect + register
   localparam int LAT      = 156;
   localparam int PM_NOM   = 16000;   // bit period in milli-clocks
   localparam int PM_FAST  = 15534;   // sender +3%
   localparam int PM_SLOW  = 16495;   // sender -3%

   typedef struct {
      int         due;
      bit         good;
      logic [7:0] b;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic ready_man = 1'b1;
   logic rand_ready = 1'b0;
   logic r_rand = 1'b1;

   uart_rx_if bus ();
   assign bus.ready = rand_ready ? r_rand : ready_man;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_rx   (rx),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      r_rand = ($urandom_range(0, 3) != 0);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   ev_t        evq[$];
   ev_t        ev;
   bit         m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   bit         acc_pend = 1'b0;
   bit         rst_prev = 1'b1;
   bit         exp_ferr, exp_ovr, loaded, ok;

   always @(negedge clk) begin
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      loaded   = 1'b0;
      if (rst_prev) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         evq.delete();
      end else begin
         if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            if (!ev.good) begin
               exp_ferr = 1'b1;
            end else if (m_valid && !acc_pend) begin
               exp_ovr = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_data  = ev.b;
               loaded  = 1'b1;
            end
         end
         if (!loaded && acc_pend) m_valid = 1'b0;
      end
      ok = (bus.valid === m_valid) && (bus.frame_err === exp_ferr) &&
           (bus.overrun === exp_ovr) && (!m_valid || bus.data === m_data) &&
           (!rst_prev || (bus.busy === 1'b0 && bus.data === 8'h00));
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL cycle_model at cycle %0d: got valid=%0b data=%h ferr=%0b ovr=%0b busy=%0b, expected valid=%0b data=%h ferr=%0b ovr=%0b",
                    cyc, bus.valid, bus.data, bus.frame_err, bus.overrun, bus.busy,
                    m_valid, m_data, exp_ferr, exp_ovr);
      acc_pend = m_valid && (bus.ready === 1'b1) && !rst;
      rst_prev = rst;
   end

   // ---------------- independent event counters ----------------
   int         rise_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = 0;
   logic [7:0] rise_data = 8'h00;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.valid && !prev_valid) begin
         rise_cnt++;
         rise_cyc  = cyc;
         rise_data = bus.data;
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun) ovr_cnt++;
      prev_valid = bus.valid;
   end

   // ---------------- stimulus ----------------
   int last_edge = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int pm, input bit noise);
      logic [9:0] bits;
      int t, start_k, end_k;
      bits = {stop_bit, b, 1'b0};
      last_edge = cyc;
      evq.push_back('{due: cyc + LAT, good: stop_bit, b: b});
      t = 0;
      for (int k = 0; k < 10; k++) begin
         start_k = t;
         end_k   = ((k + 1) * pm) / 1000;
         while (t < end_k) begin
            rx = bits[k];
            if (noise && k >= 1 && k <= 8 && (t - start_k) == 8) rx = ~bits[k];
            step();
            t++;
         end
      end
   endtask

   int r0, f0, o0, w;
   logic [7:0] rb;
   bit rgood, rnoise;
   int rpm;

   initial begin
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_valid", bus.valid === 1'b0, int'(bus.valid), 0);
      chk("reset_data", bus.data === 8'h00, int'(bus.data), 0);
      chk("reset_busy", bus.busy === 1'b0, int'(bus.busy), 0);
      idle(20);

      // nominal byte
      r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'hA5, 1'b1, PM_NOM, 1'b0);
      idle(20);
      chk("nominal_count", rise_cnt - r0 == 1, rise_cnt - r0, 1);
      chk("nominal_latency", (rise_cyc - last_edge >= 150) && (rise_cyc - last_edge <= 156),
          rise_cyc - last_edge, 156);
      chk("nominal_data", rise_data == 8'hA5, int'(rise_data), 'hA5);
      chk("nominal_no_err", (ferr_cnt == f0) && (ovr_cnt == o0), ferr_cnt + ovr_cnt, f0 + o0);

      // back-to-back
      r0 = rise_cnt;
      send_frame(8'h00, 1'b1, PM_NOM, 1'b0);
      send_frame(8'hFF, 1'b1, PM_NOM, 1'b0);
      send_frame(8'h3C, 1'b1, PM_NOM, 1'b0);
      idle(20);
      chk("b2b_count", rise_cnt - r0 == 3, rise_cnt - r0, 3);
      chk("b2b_last", rise_data == 8'h3C, int'(rise_data), 'h3C);

      // backpressure and overrun
      ready_man = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1, PM_NOM, 1'b0);
      send_frame(8'h22, 1'b1, PM_NOM, 1'b0);
      idle(20);
      chk("bp_valid_held", bus.valid === 1'b1, int'(bus.valid), 1);
      chk("bp_data_kept", bus.data === 8'h11, int'(bus.data), 'h11);
      chk("bp_overrun_once", ovr_cnt - o0 == 1, ovr_cnt - o0, 1);
      ready_man = 1'b1;
      step();
      step();
      chk("bp_valid_cleared", bus.valid === 1'b0, int'(bus.valid), 0);
      idle(10);

      // glitch rejection
      r0 = rise_cnt;
      rx = 1'b0;
      repeat (4) step();
      rx = 1'b1;
      step();
      chk("glitch_busy_rose", bus.busy === 1'b1, int'(bus.busy), 1);
      w = 0;
      while (bus.busy === 1'b1 && w < 10) begin
         step();
         w++;
      end
      chk("glitch_busy_fell", bus.busy === 1'b0, int'(bus.busy), 0);
      idle(40);
      chk("glitch_no_valid", rise_cnt == r0, rise_cnt - r0, 0);

      // framing error then break
      r0 = rise_cnt; f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, PM_NOM, 1'b0);
      rx = 1'b0;
      repeat (40 * 16) step();
      chk("break_busy", bus.busy === 1'b1, int'(bus.busy), 1);
      chk("break_ferr_once", ferr_cnt - f0 == 1, ferr_cnt - f0, 1);
      rx = 1'b1;
      w = 0;
      while (bus.busy === 1'b1 && w < 8) begin
         step();
         w++;
      end
      chk("break_exit", bus.busy === 1'b0, int'(bus.busy), 0);
      idle(20);
      chk("break_no_valid", rise_cnt == r0, rise_cnt - r0, 0);

      // noise and drift
      r0 = rise_cnt;
      send_frame(8'h96, 1'b1, PM_NOM, 1'b1);
      idle(20);
      chk("noise_data", (rise_cnt == r0 + 1) && rise_data == 8'h96, int'(rise_data), 'h96);
      send_frame(8'h96, 1'b1, PM_FAST, 1'b0);
      idle(20);
      chk("fast_data", (rise_cnt == r0 + 2) && rise_data == 8'h96, rise_cnt - r0, 2);
      send_frame(8'h96, 1'b1, PM_SLOW, 1'b0);
      idle(20);
      chk("slow_data", (rise_cnt == r0 + 3) && rise_data == 8'h96, rise_cnt - r0, 3);

      // reset mid-frame, with a byte already held so the reset is visible
      ready_man = 1'b0;
      send_frame(8'h3C, 1'b1, PM_NOM, 1'b0);
      idle(20);
      chk("pre_reset_valid", bus.valid === 1'b1, int'(bus.valid), 1);
      r0 = rise_cnt;
      fork
         send_frame(8'hC3, 1'b1, PM_NOM, 1'b0);
         begin
            repeat (16 * 5 + 4) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("midrst_valid", bus.valid === 1'b0, int'(bus.valid), 0);
            chk("midrst_data", bus.data === 8'h00, int'(bus.data), 0);
            chk("midrst_busy", bus.busy === 1'b0, int'(bus.busy), 0);
         end
      join
      ready_man = 1'b1;
      idle(30);
      chk("midrst_ignored", rise_cnt == r0, rise_cnt - r0, 0);
      send_frame(8'h5A, 1'b1, PM_NOM, 1'b0);
      idle(20);
      chk("midrst_next", (rise_cnt == r0 + 1) && rise_data == 8'h5A, int'(rise_data), 'h5A);

      // randomized traffic with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rb     = 8'($urandom);
         rgood  = ($urandom_range(0, 7) != 0);
         rnoise = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 2))
            0:       rpm = PM_FAST;
            1:       rpm = PM_SLOW;
            default: rpm = PM_NOM;
         endcase
         send_frame(rb, rgood, rpm, rnoise);
         idle($urandom_range(8, 30));
      end
      rand_ready = 1'b0;
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
